// File: rtl/comparator_pkg.sv
// Shared definitions for the magnitude-comparator BIST: default width, state
// encoding and the {ceq,clt,cgt} flag bundle ordering.
package comparator_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } bist_state_t;

    // Bit positions of each flag inside the packed {ceq,clt,cgt} bundle.
    localparam int FLAG_EQ = 2;
    localparam int FLAG_LT = 1;
    localparam int FLAG_GT = 0;

    typedef struct packed {
        logic ceq;
        logic clt;
        logic cgt;
    } flags_t;

endpackage

// File: rtl/comparator_bist_if.sv
// Operand/flag bus between the BIST driver (master) and the comparator under
// test (slave).
interface comparator_bist_if #(
    parameter int WIDTH = comparator_pkg::DEFAULT_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ceq;
    logic             clt;
    logic             cgt;

    modport master (output a, b, input ceq, clt, cgt);
    modport slave  (input a, b, output ceq, clt, cgt);
endinterface

// File: rtl/comparator_golden.sv
// Golden model of the unsigned magnitude comparator: operands in, expected
// {ceq,clt,cgt} out. Purely combinational.
module comparator_golden
    import comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output flags_t           expected
);

    assign expected.ceq = (a == b);
    assign expected.clt = (a < b);
    assign expected.cgt = (a > b);

endmodule

// File: rtl/comparator_bist.sv
// Exhaustive self-test sweep for the magnitude comparator: walks every {a,b}
// pair, checks the returned flags against the golden model, logs the first failure.
module comparator_bist
    import comparator_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    comparator_bist_if.master     cmp,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2*WIDTH:0]      err_count,
    output logic                  fail_valid,
    output logic [WIDTH-1:0]      fail_a,
    output logic [WIDTH-1:0]      fail_b
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_DRIVE  = DRIVE;
    localparam logic [1:0] S_SAMPLE = SAMPLE;
    localparam logic [1:0] S_DONE   = DONE;

    localparam int                CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   settle_cnt;
    logic [2*WIDTH-1:0] vec;        // {a,b}; b is the low half, so it is the inner loop
    flags_t             observed;
    flags_t             expected;
    logic               vec_fail;

    assign cmp.a = vec[2*WIDTH-1:WIDTH];
    assign cmp.b = vec[WIDTH-1:0];

    comparator_golden #(.WIDTH(WIDTH)) u_golden (
        .a        (vec[2*WIDTH-1:WIDTH]),
        .b        (vec[WIDTH-1:0]),
        .expected (expected)
    );

    assign observed.ceq = cmp.ceq;
    assign observed.clt = cmp.clt;
    assign observed.cgt = cmp.cgt;
    // Any flag disagreeing fails the vector, which also catches multiple-high flags.
    assign vec_fail     = (observed != expected);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            vec        <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_DRIVE;
                        settle_cnt <= '0;
                        vec        <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                    end
                end
                S_DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (vec_fail) begin
                        // Sweep has at most 2^(2*WIDTH) vectors, so this cannot wrap.
                        err_count <= err_count + 1'b1;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_a     <= vec[2*WIDTH-1:WIDTH];
                            fail_b     <= vec[WIDTH-1:0];
                        end
                    end
                    if (&vec) begin
                        state <= S_DONE;
                    end else begin
                        vec        <= vec + 1'b1;
                        settle_cnt <= '0;
                        state      <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_DRIVE) || (state == S_SAMPLE);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == '0);

endmodule
